// File: rtl/snitch_clint_ctrl.sv
// Core-local interruptor: mtime counter on a synchronised RTC tick, per-core
// mtimecmp/msip registers, and a single-outstanding request/response register port.
module snitch_clint_ctrl #(
  parameter int unsigned NrCores   = 8,
  parameter int unsigned AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rtc_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NrCores-1:0]   msip_o,
  output logic [NrCores-1:0]   mtip_o
);

  localparam logic [15:0] MtimeLoAddr = 16'hBFF8;

  typedef enum logic [1:0] {
    RegNone,
    RegMsip,
    RegCmp,
    RegMtime
  } reg_sel_e;

  // Handshake: a request is accepted on a clock edge where req_valid_i and
  // req_ready_o are both high; its response is valid from the next cycle and
  // stays valid with stable payload until an edge where rsp_ready_i is high.
  // req_ready_o is high whenever the response slot is empty or being drained.

  logic [NrCores-1:0] msip_q, msip_d;
  logic [NrCores-1:0] mtip_q, mtip_d;
  logic [63:0]        mtimecmp_q [NrCores];
  logic [63:0]        mtimecmp_d [NrCores];
  logic [63:0]        mtime_q, mtime_d;
  logic [2:0]         rtc_sync_q, rtc_sync_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;

  logic [15:0] addr_lo;
  logic        addr_hi_zero;
  logic [11:0] msip_idx;
  logic [10:0] cmp_idx;
  logic        word_hi;
  reg_sel_e    sel;
  logic        hit;
  logic [31:0] rdata;
  logic        req_fire;
  logic        wr_fire;
  logic        rtc_tick;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  assign addr_lo      = req_addr_i[15:0];
  assign addr_hi_zero = ((req_addr_i >> 16) == '0);

  // Address decode; anything that does not select a register is an error.
  always_comb begin
    sel      = RegNone;
    msip_idx = addr_lo[13:2];
    cmp_idx  = addr_lo[13:3];
    word_hi  = addr_lo[2];
    if (addr_hi_zero && (addr_lo[1:0] == 2'b00)) begin
      if (addr_lo[15:14] == 2'b00) begin
        if (32'(msip_idx) < NrCores) sel = RegMsip;
      end else if (addr_lo[15:14] == 2'b01) begin
        if (32'(cmp_idx) < NrCores) sel = RegCmp;
      end else if (addr_lo[15:3] == MtimeLoAddr[15:3]) begin
        sel = RegMtime;
      end
    end
  end

  assign hit = (sel != RegNone);

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      if ((sel == RegMsip) && (32'(msip_idx) == i)) rdata = {31'b0, msip_q[i]};
      if ((sel == RegCmp) && (32'(cmp_idx) == i)) begin
        rdata = word_hi ? mtimecmp_q[i][63:32] : mtimecmp_q[i][31:0];
      end
    end
    if (sel == RegMtime) rdata = word_hi ? mtime_q[63:32] : mtime_q[31:0];
  end

  assign req_ready_o = !rsp_valid_q | rsp_ready_i;
  assign req_fire    = req_valid_i & req_ready_o;
  assign wr_fire     = req_fire & req_write_i & hit;

  // s0 = [0], s1 = [1], s2 = [2]; a tick is a rising edge seen at s1.
  always_comb begin
    rtc_sync_d = {rtc_sync_q[1:0], rtc_i};
  end
  assign rtc_tick = rtc_sync_q[1] & ~rtc_sync_q[2];

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    for (int unsigned i = 0; i < NrCores; i++) begin
      if (wr_fire && (sel == RegMsip) && (32'(msip_idx) == i) && req_wstrb_i[0]) begin
        msip_d[i] = req_wdata_i[0];
      end
      if (wr_fire && (sel == RegCmp) && (32'(cmp_idx) == i)) begin
        if (word_hi) begin
          mtimecmp_d[i][63:32] = apply_strb(mtimecmp_q[i][63:32], req_wdata_i, req_wstrb_i);
        end else begin
          mtimecmp_d[i][31:0] = apply_strb(mtimecmp_q[i][31:0], req_wdata_i, req_wstrb_i);
        end
      end
    end
  end

  // A software write to mtime wins over a coincident tick; unwritten bytes keep
  // the pre-tick value.
  always_comb begin
    mtime_d = mtime_q + 64'(rtc_tick);
    if (wr_fire && (sel == RegMtime)) begin
      mtime_d = mtime_q;
      if (word_hi) begin
        mtime_d[63:32] = apply_strb(mtime_q[63:32], req_wdata_i, req_wstrb_i);
      end else begin
        mtime_d[31:0] = apply_strb(mtime_q[31:0], req_wdata_i, req_wstrb_i);
      end
    end
  end

  always_comb begin
    mtip_d = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      mtip_d[i] = (mtime_q >= mtimecmp_q[i]);
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = !hit;
      rsp_rdata_d = (hit && !req_write_i) ? rdata : 32'h0;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      msip_q      <= '0;
      mtip_q      <= '0;
      mtime_q     <= '0;
      rtc_sync_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      for (int unsigned i = 0; i < NrCores; i++) begin
        mtimecmp_q[i] <= '1;
      end
    end else begin
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      mtime_q     <= mtime_d;
      rtc_sync_q  <= rtc_sync_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      for (int unsigned i = 0; i < NrCores; i++) begin
        mtimecmp_q[i] <= mtimecmp_d[i];
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign msip_o      = msip_q;
  assign mtip_o      = mtip_q;

endmodule

// File: tb/tb_snitch_clint_ctrl.sv
// Bench for snitch_clint_ctrl: a register-map-level reference model checked every
// cycle, plus directed accesses with hand-computed expected values.
module tb_snitch_clint_ctrl;

  localparam int NC = 8;
  localparam int K_ERR = 0, K_MSIP = 1, K_CMP = 2, K_MT = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rtc_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [15:0]   req_addr_i;
  logic          req_write_i;
  logic [31:0]   req_wdata_i;
  logic [3:0]    req_wstrb_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_error_o;
  logic [NC-1:0] msip_o;
  logic [NC-1:0] mtip_o;

  snitch_clint_ctrl #(.NrCores(NC), .AddrWidth(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rtc_i       (rtc_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_write_i (req_write_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .msip_o      (msip_o),
    .mtip_o      (mtip_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NC-1:0] m_msip, m_mtip;
  logic [63:0]   m_cmp [NC];
  logic [63:0]   m_mtime;
  logic          m_rsp_valid;
  logic [31:0]   m_rdata;
  logic          m_err;
  int            edge_n;
  int            tick_at[$];
  logic          rtc_prev;

  function automatic void decode(input int a, output int kind, output int idx, output bit hi);
    kind = K_ERR; idx = 0; hi = 1'b0;
    if (a % 4 != 0) return;
    if (a < 4 * NC) begin
      kind = K_MSIP; idx = a / 4;
    end else if (a >= 'h4000 && a < 'h4000 + 8 * NC) begin
      kind = K_CMP; idx = (a - 'h4000) / 8; hi = ((a % 8) == 4);
    end else if (a == 'hBFF8 || a == 'hBFFC) begin
      kind = K_MT; hi = (a == 'hBFFC);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic model_step();
    int          e, kind, idx;
    bit          hi, do_tick, acc;
    logic [31:0] rd;
    logic [63:0] nt;
    logic [NC-1:0] nmsip, nmtip;
    logic [63:0] ncmp [NC];
    e = edge_n + 1;
    for (int i = 0; i < NC; i++) nmtip[i] = (m_mtime >= m_cmp[i]);
    // a rising rtc seen at edge k advances mtime at edge k+2
    do_tick = (tick_at.size() > 0) && (tick_at[0] == e);
    if (do_tick) void'(tick_at.pop_front());
    if (rtc_i && !rtc_prev) tick_at.push_back(e + 2);
    nt    = do_tick ? m_mtime + 64'd1 : m_mtime;
    nmsip = m_msip;
    ncmp  = m_cmp;
    acc   = req_valid_i && (!m_rsp_valid || rsp_ready_i);
    if (acc) begin
      decode(int'(req_addr_i), kind, idx, hi);
      rd = 32'h0;
      case (kind)
        K_MSIP:  rd = {31'b0, m_msip[idx]};
        K_CMP:   rd = hi ? m_cmp[idx][63:32] : m_cmp[idx][31:0];
        K_MT:    rd = hi ? m_mtime[63:32] : m_mtime[31:0];
        default: rd = 32'h0;
      endcase
      if (req_write_i) begin
        case (kind)
          K_MSIP: if (req_wstrb_i[0]) nmsip[idx] = req_wdata_i[0];
          K_CMP: begin
            if (hi) ncmp[idx][63:32] = merge(m_cmp[idx][63:32], req_wdata_i, req_wstrb_i);
            else    ncmp[idx][31:0]  = merge(m_cmp[idx][31:0], req_wdata_i, req_wstrb_i);
          end
          K_MT: begin
            nt = m_mtime;
            if (hi) nt[63:32] = merge(m_mtime[63:32], req_wdata_i, req_wstrb_i);
            else    nt[31:0]  = merge(m_mtime[31:0], req_wdata_i, req_wstrb_i);
          end
          default: ;
        endcase
      end
      m_rsp_valid <= 1'b1;
      m_err       <= (kind == K_ERR);
      m_rdata     <= (kind == K_ERR || req_write_i) ? 32'h0 : rd;
    end else if (rsp_ready_i) begin
      m_rsp_valid <= 1'b0;
    end
    rtc_prev <= rtc_i;
    edge_n   <= e;
    m_msip   <= nmsip;
    m_cmp    <= ncmp;
    m_mtime  <= nt;
    m_mtip   <= nmtip;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_msip      <= '0;
      m_mtip      <= '0;
      m_mtime     <= '0;
      m_rsp_valid <= 1'b0;
      m_rdata     <= '0;
      m_err       <= 1'b0;
      edge_n      <= 0;
      rtc_prev    <= 1'b0;
      tick_at.delete();
      for (int i = 0; i < NC; i++) m_cmp[i] <= '1;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      check("cyc_msip", 64'(msip_o), 64'(m_msip));
      check("cyc_mtip", 64'(mtip_o), 64'(m_mtip));
      check("cyc_rsp_valid", 64'(rsp_valid_o), 64'(m_rsp_valid));
      check("cyc_req_ready", 64'(req_ready_o), 64'(!m_rsp_valid || rsp_ready_i));
      if (m_rsp_valid) begin
        check("cyc_rdata", 64'(rsp_rdata_o), 64'(m_rdata));
        check("cyc_error", 64'(rsp_error_o), 64'(m_err));
      end
    end
  end

  // ---------------- driver tasks (called at a falling clock edge) ----------------
  task automatic access(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er);
    int guard;
    guard = 0;
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a; req_wdata_i = wd; req_wstrb_i = st;
    #1;
    while (!req_ready_o && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    check("req_accept_timeout", 64'(guard >= 20), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    rd = rsp_rdata_o;
    er = rsp_error_o;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic        e;
    access(1'b0, a, 32'h0, 4'h0, d, e);
    check({name, "_rdata"}, 64'(d), 64'(exp_d));
    check({name, "_err"}, 64'(e), 64'(exp_e));
  endtask

  task automatic wr_chk(input string name, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic exp_e);
    logic [31:0] d;
    logic        e;
    access(1'b1, a, wd, st, d, e);
    check({name, "_rdata"}, 64'(d), 64'd0);
    check({name, "_err"}, 64'(e), 64'(exp_e));
  endtask

  task automatic do_rtc_tick();
    rtc_i = 1'b1;
    repeat (3) @(negedge clk);
    rtc_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rtc_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_wstrb_i = '0; rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_msip", 64'(msip_o), 64'd0);
    check("rst_mtip", 64'(mtip_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rdata", 64'(rsp_rdata_o), 64'd0);
    check("rst_error", 64'(rsp_error_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("rst_mtime_lo", 16'hBFF8, 32'h0, 1'b0);
    rd_chk("rst_mtime_hi", 16'hBFFC, 32'h0, 1'b0);
    rd_chk("rst_cmp0_lo", 16'h4000, 32'hFFFF_FFFF, 1'b0);
    rd_chk("rst_cmp0_hi", 16'h4004, 32'hFFFF_FFFF, 1'b0);

    // software interrupt
    wr_chk("msip2_set", 16'h0008, 32'h1, 4'hF, 1'b0);
    check("msip2_at_accept", 64'(msip_o), 64'h04);
    rd_chk("msip2_read", 16'h0008, 32'h1, 1'b0);
    wr_chk("msip2_clr", 16'h0008, 32'h0, 4'hF, 1'b0);
    check("msip2_cleared", 64'(msip_o), 64'h00);
    wr_chk("msip2_strb0", 16'h0008, 32'h1, 4'h0, 1'b0);
    check("msip2_strb0_noop", 64'(msip_o), 64'h00);
    wr_chk("msip_oob", 16'h0020, 32'h1, 4'hF, 1'b1);
    check("msip_oob_nochange", 64'(msip_o), 64'h00);

    // errors
    rd_chk("unaligned", 16'h4002, 32'h0, 1'b1);
    rd_chk("unmapped", 16'hC000, 32'h0, 1'b1);
    rd_chk("cmp_oob", 16'h4040, 32'h0, 1'b1);

    // timer interrupt on core 1
    wr_chk("cmp1_lo", 16'h4008, 32'h5, 4'hF, 1'b0);
    wr_chk("cmp1_hi", 16'h400C, 32'h0, 4'hF, 1'b0);
    repeat (4) do_rtc_tick();
    check("mtip_before5", 64'(mtip_o), 64'h00);
    rtc_i = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("mtip_at_mtime5", 64'(mtip_o), 64'h00);
    @(negedge clk);
    #1 check("mtip_after_mtime5", 64'(mtip_o), 64'h02);
    rtc_i = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("mtime_is5", 16'hBFF8, 32'h5, 1'b0);
    wr_chk("cmp1_hi_max", 16'h400C, 32'hFFFF_FFFF, 4'hF, 1'b0);
    #1 check("mtip1_still_high", 64'(mtip_o), 64'h02);
    @(negedge clk);
    #1 check("mtip1_fell", 64'(mtip_o), 64'h00);

    // carry and wrap
    @(negedge clk);
    wr_chk("mt_lo_ones", 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr_chk("mt_hi_zero", 16'hBFFC, 32'h0, 4'hF, 1'b0);
    do_rtc_tick();
    rd_chk("carry_lo", 16'hBFF8, 32'h0, 1'b0);
    rd_chk("carry_hi", 16'hBFFC, 32'h1, 1'b0);
    wr_chk("mt_lo_max", 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr_chk("mt_hi_max", 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0);
    @(negedge clk);
    #1 check("mtip_all_at_max", 64'(mtip_o), 64'hFF);
    @(negedge clk);
    do_rtc_tick();
    rd_chk("wrap_lo", 16'hBFF8, 32'h0, 1'b0);
    rd_chk("wrap_hi", 16'hBFFC, 32'h0, 1'b0);
    check("mtip_after_wrap", 64'(mtip_o), 64'h00);

    // write colliding with a tick
    wr_chk("mt_lo_100", 16'hBFF8, 32'h100, 4'hF, 1'b0);
    rtc_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_chk("collide_wr", 16'hBFF8, 32'hAA, 4'h1, 1'b0);
    rtc_i = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("collide_lo", 16'hBFF8, 32'h1AA, 1'b0);
    do_rtc_tick();
    rd_chk("resume_lo", 16'hBFF8, 32'h1AB, 1'b0);

    // backpressure with a request waiting
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 16'h4008; req_wstrb_i = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    req_write_i = 1'b1; req_addr_i = 16'h0000; req_wdata_i = 32'h1; req_wstrb_i = 4'h1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready", 64'(req_ready_o), 64'd0);
      check("bp_rdata", 64'(rsp_rdata_o), 64'h5);
      check("bp_valid", 64'(rsp_valid_o), 64'd1);
      check("bp_msip", 64'(msip_o), 64'h00);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    check("bp_wr_applied", 64'(msip_o), 64'h01);
    check("bp_wr_rdata", 64'(rsp_rdata_o), 64'h0);

    // back-to-back accesses
    @(negedge clk);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 16'hBFF8;
    @(posedge clk);
    @(negedge clk);
    req_addr_i = 16'h4008;
    #1;
    check("b2b_first", 64'(rsp_rdata_o), 64'h1AB);
    check("b2b_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_write_i = 1'b1; req_addr_i = 16'h0000; req_wdata_i = 32'h0; req_wstrb_i = 4'hF;
    #1 check("b2b_second", 64'(rsp_rdata_o), 64'h5);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    check("b2b_third_msip", 64'(msip_o), 64'h00);
    check("b2b_third_valid", 64'(rsp_valid_o), 64'd1);

    // reset while a response is pending
    @(negedge clk);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 16'h4008;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    rst_n = 1'b0;
    #1 check("midrst_valid", 64'(rsp_valid_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("postrst_valid", 64'(rsp_valid_o), 64'd0);
      check("postrst_ready", 64'(req_ready_o), 64'd1);
    end
    @(negedge clk);
    rsp_ready_i = 1'b1;
    rd_chk("postrst_cmp1", 16'h4008, 32'hFFFF_FFFF, 1'b0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
